// File: rtl/packet_writer_if.sv
// Bus bundles between packet_writer and the downstream RingBuffer.
//   IPush              : data[15:0], request (writer -> buffer); done (buffer -> writer,
//                        write acknowledge).
//   IRingBufferControl : open, commit, rollback (writer -> buffer, 1-cycle pulses);
//                        memUsed[ADDR_W-1:0] (buffer -> writer, committed occupancy).

interface IPush;
  logic [15:0] data;
  logic        request;
  logic        done;

  modport master (output data, output request, input done);
  modport slave  (input data, input request, output done);
endinterface

interface IRingBufferControl #(
  parameter int unsigned ADDR_W = 16
);
  logic              open;
  logic              commit;
  logic              rollback;
  logic [ADDR_W-1:0] memUsed;

  modport master (output open, output commit, output rollback, input memUsed);
  modport slave  (input open, input commit, input rollback, output memUsed);
endinterface

// File: rtl/packet_writer.sv
// packet_writer: frames MIL-1553 words from a line receiver into RingBuffer transactions.
// A packet (sop..eop) is opened, each word is pushed with a request/done handshake and the
// packet is committed after the last word; corrupt or non-fitting packets are rolled back
// and counted in dropCount.
// Ports:
//   clk, nRst            single clock, synchronous active-low reset
//   in_valid/in_data/in_sop/in_eop/in_err/in_ready   upstream word stream
//   push     (IPush.master)               word write handshake to the RingBuffer
//   control  (IRingBufferControl.master)  open/commit/rollback pulses, memUsed occupancy
//   dropCount                              saturating count of discarded packets
// Build option: define PACKET_WRITER_TRAILER_EN to append a {8'h00, word count} trailer word
// to every packet before it is committed.

module packet_writer #(
  parameter int unsigned CAPACITY = 16'd255,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     in_valid,
  input  logic [15:0]              in_data,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic                     in_err,
  output logic                     in_ready,
  IPush.master                     push,
  IRingBufferControl.master        control,
  output logic [7:0]               dropCount
);

`ifdef PACKET_WRITER_TRAILER_EN
  localparam int unsigned TrailerWords = 1;
`else
  localparam int unsigned TrailerWords = 0;
`endif
  localparam int unsigned SumW = ADDR_W + 2;

  typedef enum logic [2:0] {StIdle, StWaitWord, StPush, StCommit, StDrop} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       data_q, data_d;
  logic              req_q, req_d;
  logic              eop_q, eop_d;
  logic              trl_q, trl_d;
  logic              rb_q, rb_d;
  logic              rb_late_q, rb_late_d;
  logic              open_q, open_d;
  logic              rdy_q;
  logic [7:0]        drop_q, drop_d;

  logic              acc, start, take, open_now, rb_now, overflow;
  logic [1:0]        drop_inc;
  logic [ADDR_W-1:0] base;
  logic [SumW-1:0]   need;
  logic [8:0]        drop_sum;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    req_d     = req_q;
    eop_d     = eop_q;
    trl_d     = trl_q;
    rb_d      = rb_late_q;  // deferred rollback moves into the output slot
    rb_late_d = 1'b0;
    open_d    = 1'b0;
    drop_inc  = 2'd0;
    open_now  = 1'b0;
    rb_now    = 1'b0;
    start     = 1'b0;
    take      = 1'b0;

    // Hold input off while a registered pulse is pending so a following sop cannot
    // produce an open in the same cycle as that pulse.
    in_ready = rdy_q & ~rb_q & ~rb_late_q & ~open_q &
               (state_q == StIdle || state_q == StWaitWord || state_q == StDrop);
    acc = in_valid & in_ready;

    unique case (state_q)
      StIdle: begin
        if (acc && in_sop) begin
          open_now = 1'b1;
          start    = 1'b1;
        end
      end
      StWaitWord: begin
        if (acc) begin
          if (in_sop) begin
            // Abandon the unfinished packet now, open the new one next cycle.
            rb_now   = 1'b1;
            open_d   = 1'b1;
            drop_inc = 2'd1;
            start    = 1'b1;
          end else begin
            take = 1'b1;
          end
        end
      end
      StPush: begin
        if (!req_q) begin
          req_d = 1'b1;  // re-raise request for the trailer word
        end else if (push.done) begin
          req_d = 1'b0;
          if (trl_q) begin
            trl_d   = 1'b0;
            state_d = StCommit;
          end else if (eop_q) begin
`ifdef PACKET_WRITER_TRAILER_EN
            trl_d  = 1'b1;
            data_d = {8'h00, cnt_q[7:0]};
`else
            state_d = StCommit;
`endif
          end else begin
            state_d = StWaitWord;
          end
        end
      end
      StCommit: state_d = StIdle;
      StDrop: begin
        if (acc) begin
          if (in_sop) begin
            open_now = 1'b1;
            start    = 1'b1;
          end else if (in_eop) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // memUsed only covers committed words, so the words already pushed for this packet
    // (cnt) and the trailer slot must be added explicitly.
    base     = start ? '0 : cnt_q;
    need     = SumW'(control.memUsed) + SumW'(base) + SumW'(1 + TrailerWords);
    overflow = need > SumW'(CAPACITY);

    if (start || take) begin
      if (in_err || overflow) begin
        drop_inc = drop_inc + 2'd1;
        if (rb_now) rb_late_d = 1'b1;  // queue behind the deferred open
        else        rb_d      = 1'b1;
        cnt_d   = '0;
        state_d = in_eop ? StIdle : StDrop;
      end else begin
        data_d  = in_data;
        req_d   = 1'b1;
        eop_d   = in_eop;
        trl_d   = 1'b0;
        cnt_d   = base + 1'b1;
        state_d = StPush;
      end
    end

    drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
    drop_d   = drop_sum[8] ? 8'hff : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      eop_q     <= 1'b0;
      trl_q     <= 1'b0;
      rb_q      <= 1'b0;
      rb_late_q <= 1'b0;
      open_q    <= 1'b0;
      rdy_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      req_q     <= req_d;
      eop_q     <= eop_d;
      trl_q     <= trl_d;
      rb_q      <= rb_d;
      rb_late_q <= rb_late_d;
      open_q    <= open_d;
      rdy_q     <= 1'b1;
      drop_q    <= drop_d;
    end
  end

  assign push.data        = data_q;
  assign push.request     = req_q;
  assign control.open     = open_now | open_q;
  assign control.rollback = rb_now | rb_q;
  assign control.commit   = (state_q == StCommit);
  assign dropCount        = drop_q;

endmodule

// File: tb/tb_packet_writer.sv
// Directed bench for packet_writer (CAPACITY = 4). A RingBuffer model acknowledges each
// push two cycles after request; a negedge monitor counts bus pulses and logs pushed words.

module tb_packet_writer;

`ifdef PACKET_WRITER_TRAILER_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  logic        in_ready;
  logic [7:0]  dropCount;
  logic [15:0] mem_used = 16'd0;
  logic        done_auto = 1'b0, done_poke = 1'b0;

  IPush push_if ();
  IRingBufferControl #(.ADDR_W(16)) ctl_if ();

  assign push_if.done   = done_auto | done_poke;
  assign ctl_if.memUsed = mem_used;

  packet_writer #(.CAPACITY(4), .ADDR_W(16)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_err    (in_err),
    .in_ready  (in_ready),
    .push      (push_if.master),
    .control   (ctl_if.master),
    .dropCount (dropCount)
  );

  always #5 clk = ~clk;

  // RingBuffer model: done one cycle wide, two cycles after request rises.
  int age = 0;
  always @(posedge clk) begin
    #1;
    if (done_auto) begin
      done_auto = 1'b0;
      age = 0;
    end else if (push_if.request) begin
      age++;
      if (age == 2) begin
        done_auto = 1'b1;
        age = 0;
      end
    end else begin
      age = 0;
    end
  end

  // Monitor.
  int cyc = 0, n_open = 0, n_commit = 0, n_rb = 0, n_push = 0, viol = 0;
  int last_open_cyc = 0, last_rb_cyc = 0;
  logic [15:0] push_log [64];
  logic [15:0] last_data = 16'h0;
  always @(negedge clk) begin
    cyc++;
    if (ctl_if.open)     begin n_open++; last_open_cyc = cyc; end
    if (ctl_if.commit)   n_commit++;
    if (ctl_if.rollback) begin n_rb++; last_rb_cyc = cyc; end
    if (push_if.request && push_if.done) begin
      push_log[n_push % 64] = push_if.data;
      last_data = push_if.data;
      n_push++;
    end
    if (int'(ctl_if.open) + int'(ctl_if.commit) + int'(ctl_if.rollback) > 1) viol++;
    if (push_if.request && (ctl_if.commit || ctl_if.rollback)) viol++;
  end

  int checks = 0, passed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic s, input logic e, input logic r, input logic [15:0] d);
    int n = 0;
    in_valid = 1'b1; in_sop = s; in_eop = e; in_err = r; in_data = d;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 40);
    chk("accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
  endtask

  int o0, c0, r0, p0;
  task automatic snap();
    o0 = n_open; c0 = n_commit; r0 = n_rb; p0 = n_push;
  endtask

  initial begin
    // Reset state.
    cycles(3);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_request", {31'd0, push_if.request}, 32'd0);
    chk("rst_data", {16'd0, push_if.data}, 32'd0);
    chk("rst_pulses", {29'd0, ctl_if.open, ctl_if.commit, ctl_if.rollback}, 32'd0);
    chk("rst_drop", {24'd0, dropCount}, 32'd0);
    nRst = 1'b1;
    chk("rel_ready_lo", {31'd0, in_ready}, 32'd0);
    cycles(1);
    chk("rel_ready_hi", {31'd0, in_ready}, 32'd1);

    // 3-word packet, empty buffer.
    snap();
    send(1, 0, 0, 16'hA001);
    send(0, 0, 0, 16'hA002);
    send(0, 1, 0, 16'hA003);
    cycles(12);
    chk("a_open", n_open - o0, 1);
    chk("a_pushes", n_push - p0, 3 + TRL);
    chk("a_w0", {16'd0, push_log[p0 % 64]}, 32'hA001);
    chk("a_w1", {16'd0, push_log[(p0 + 1) % 64]}, 32'hA002);
    chk("a_w2", {16'd0, push_log[(p0 + 2) % 64]}, 32'hA003);
    chk("a_last", {16'd0, last_data}, (TRL == 1) ? 32'h0003 : 32'hA003);
    chk("a_commit", n_commit - c0, 1);
    chk("a_rb", n_rb - r0, 0);

    // Overflow: memUsed = 2 of 4.
    mem_used = 16'd2;
    snap();
    send(1, 0, 0, 16'hB001);
    send(0, 0, 0, 16'hB002);
    send(0, 1, 0, 16'hB003);
    cycles(12);
    chk("b_pushes", n_push - p0, 2 - TRL);
    chk("b_rb", n_rb - r0, 1);
    chk("b_commit", n_commit - c0, 0);
    chk("b_drop", {24'd0, dropCount}, 32'd1);

    // Exact fit at the capacity boundary.
    mem_used = 16'(1 - TRL);
    snap();
    send(1, 0, 0, 16'hC101);
    send(0, 0, 0, 16'hC102);
    send(0, 1, 0, 16'hC103);
    cycles(12);
    chk("c_commit", n_commit - c0, 1);
    chk("c_rb", n_rb - r0, 0);
    chk("c_drop", {24'd0, dropCount}, 32'd1);

    // in_err on word 2 of 4.
    mem_used = 16'd0;
    snap();
    send(1, 0, 0, 16'hD001);
    send(0, 0, 1, 16'hD002);
    send(0, 0, 0, 16'hD003);
    send(0, 1, 0, 16'hD004);
    cycles(6);
    chk("d_pushes", n_push - p0, 1);
    chk("d_rb", n_rb - r0, 1);
    chk("d_commit", n_commit - c0, 0);
    chk("d_drop", {24'd0, dropCount}, 32'd2);

    // Word without sop in IDLE is discarded silently.
    snap();
    send(0, 1, 0, 16'hE0E0);
    cycles(4);
    chk("e_open", n_open - o0, 0);
    chk("e_pushes", n_push - p0, 0);
    chk("e_drop", {24'd0, dropCount}, 32'd2);

    // sop at word 3 of an unfinished packet.
    snap();
    send(1, 0, 0, 16'hF001);
    send(0, 0, 0, 16'hF002);
    send(1, 0, 0, 16'hF101);
    send(0, 1, 0, 16'hF102);
    cycles(12);
    chk("f_rb", n_rb - r0, 1);
    chk("f_open", n_open - o0, 2);
    chk("f_rb_then_open", last_open_cyc - last_rb_cyc, 1);
    chk("f_commit", n_commit - c0, 1);
    chk("f_pushes", n_push - p0, 4 + TRL);
    chk("f_drop", {24'd0, dropCount}, 32'd3);

    // Stray done while no request is outstanding.
    snap();
    done_poke = 1'b1;
    cycles(1);
    done_poke = 1'b0;
    cycles(3);
    chk("g_pushes", n_push - p0, 0);
    chk("g_commit", n_commit - c0, 0);
    chk("g_ready", {31'd0, in_ready}, 32'd1);

    // Reset while a push is outstanding.
    snap();
    send(1, 0, 0, 16'h7001);
    chk("h_req_before", {31'd0, push_if.request}, 32'd1);
    nRst = 1'b0;
    cycles(1);
    chk("h_request", {31'd0, push_if.request}, 32'd0);
    chk("h_ready", {31'd0, in_ready}, 32'd0);
    chk("h_pulses", {29'd0, ctl_if.open, ctl_if.commit, ctl_if.rollback}, 32'd0);
    chk("h_drop", {24'd0, dropCount}, 32'd0);
    cycles(2);
    nRst = 1'b1;
    cycles(4);
    chk("h_no_commit", n_commit - c0, 0);
    chk("h_no_rb", n_rb - r0, 0);
    send(1, 0, 0, 16'h7101);
    send(0, 1, 0, 16'h7102);
    cycles(12);
    chk("h2_commit", n_commit - c0, 1);
    chk("h2_last", {16'd0, last_data}, (TRL == 1) ? 32'h0002 : 32'h7102);

    chk("bus_exclusive", viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
